// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: one shared ALU, round-robin between two valid/ready requesters.
// Define ALU_FLAGS_EN to add {carry, zero} flag outputs per response port.
module alu_share_arbiter #(
  parameter int DATA_W  = 8,
  parameter int RR_INIT = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [2:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [2:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_data,
`ifdef ALU_FLAGS_EN
  output logic [1:0]        rsp0_flags,
  output logic [1:0]        rsp1_flags,
`endif
  output logic              busy,
  output logic              grant_id
);
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;
  state_t            state;
  logic              rr_ptr;
  logic [2:0]        op_q;
  logic [DATA_W-1:0] a_q, b_q, res_q, alu;
  logic              gnt, accept, rsp_hs;
  // Grant is decided combinationally so ready can rise in the same IDLE cycle.
  assign gnt        = (req0_valid & req1_valid) ? rr_ptr : req1_valid;
  assign accept     = reset_n & (state == IDLE) & (req0_valid | req1_valid);
  assign req0_ready = accept & ~gnt;
  assign req1_ready = accept & gnt;
  assign rsp0_valid = (state == RESP) & ~grant_id;
  assign rsp1_valid = (state == RESP) & grant_id;
  assign rsp0_data  = res_q;
  assign rsp1_data  = res_q;
  assign rsp_hs     = grant_id ? (rsp1_valid & rsp1_ready) : (rsp0_valid & rsp0_ready);
  assign busy       = (state != IDLE);
  always_comb begin
    case (op_q)
      3'd0:    alu = a_q - b_q;
      3'd1:    alu = a_q + b_q;
      3'd2:    alu = a_q & b_q;
      3'd3:    alu = a_q | b_q;
      3'd4:    alu = a_q ^ b_q;
      3'd5:    alu = DATA_W'(5);
      default: alu = DATA_W'(b_q[3:0]);
    endcase
  end
`ifdef ALU_FLAGS_EN
  logic [1:0] flags_q;
  logic       carry;
  // A wrapped sum is smaller than either addend exactly when the add carried out.
  assign carry      = (op_q == 3'd1) ? ((a_q + b_q) < a_q) : (op_q == 3'd0) ? (a_q < b_q) : 1'b0;
  assign rsp0_flags = flags_q;
  assign rsp1_flags = flags_q;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) flags_q <= '0;
    else if (state == EXEC) flags_q <= {carry, alu == '0};
`endif
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      rr_ptr   <= 1'(RR_INIT);
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      grant_id <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_q     <= gnt ? req1_op : req0_op;
          a_q      <= gnt ? req1_a : req0_a;
          b_q      <= gnt ? req1_b : req0_b;
          grant_id <= gnt;
          state    <= EXEC;
        end
        EXEC: begin
          res_q <= alu;
          state <= RESP;
        end
        RESP: if (rsp_hs) begin
          rr_ptr <= ~grant_id;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
